// File: rtl/wac_sample_reader.sv
// Read-back engine: walks the two-byte sample records in the shared BRAM, rebuilds
// each 12-bit sample and streams it out over a valid/ready handshake.
`timescale 1ns/1ps
module wac_sample_reader #(
  parameter int ADDR_W      = 12,
  parameter int DATA_BASE   = 3,
  parameter int MAX_SAMPLES = 2046
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [11:0]       n_samples,
  input  logic              busy_wr,
  input  logic [7:0]        bram_dout,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_en,
  output logic [11:0]       sample_out,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              active,
  output logic              done,
  output logic              fmt_err
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WAIT = 3'd1;
  localparam logic [2:0] RD_H = 3'd2;
  localparam logic [2:0] RD_L = 3'd3;
  localparam logic [2:0] CAP  = 3'd4;
  localparam logic [2:0] PRES = 3'd5;
  localparam logic [2:0] DONE = 3'd6;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [11:0]       n_lat;
  logic [11:0]       k;
  logic [11:0]       k_inc;
  logic [11:0]       n_req;
  logic [3:0]        hi;
  logic [ADDR_W-1:0] rec_addr;

  // Requests beyond the sample area are limited so address arithmetic never wraps.
  function automatic logic [11:0] clamp_count(input logic [11:0] req);
    if (int'(req) > MAX_SAMPLES) return 12'(MAX_SAMPLES);
    return req;
  endfunction

  assign n_req    = clamp_count(n_samples);
  assign k_inc    = k + 12'd1;
  assign rec_addr = ADDR_W'(DATA_BASE) + ADDR_W'({k, 1'b0});

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (n_req == 12'd0) ? DONE : WAIT;
      WAIT: if (!busy_wr) state_nxt = RD_H;
      RD_H: state_nxt = RD_L;
      RD_L: state_nxt = CAP;
      CAP:  state_nxt = PRES;
      PRES: if (sample_ready) state_nxt = (k_inc == n_lat) ? DONE : WAIT;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      n_lat        <= '0;
      k            <= '0;
      hi           <= '0;
      bram_addr    <= '0;
      bram_en      <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      active       <= 1'b0;
      done         <= 1'b0;
      fmt_err      <= 1'b0;
    end else begin
      state   <= state_nxt;
      bram_en <= (state_nxt == RD_H) || (state_nxt == RD_L);
      active  <= (state_nxt != IDLE) && (state_nxt != DONE);
      done    <= (state_nxt == DONE);
      if (state_nxt == RD_H)      bram_addr <= rec_addr;
      else if (state_nxt == RD_L) bram_addr <= rec_addr + ADDR_W'(1);

      case (state)
        IDLE: if (start) begin
          n_lat   <= n_req;
          k       <= '0;
          fmt_err <= 1'b0;
        end
        RD_L: begin
          hi <= bram_dout[3:0];
          if (bram_dout[7:4] != 4'h0) fmt_err <= 1'b1;
        end
        CAP: begin
          sample_out   <= {hi, bram_dout};
          sample_valid <= 1'b1;
        end
        PRES: if (sample_ready) begin
          sample_valid <= 1'b0;
          k            <= k_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wac_sample_reader.sv
// Directed bench for wac_sample_reader with a one-cycle-latency BRAM model.
`timescale 1ns/1ps
module tb_wac_sample_reader;

  logic        clk = 1'b0;
  logic        rst_n, start, busy_wr, sample_ready;
  logic [11:0] n_samples, bram_addr, sample_out;
  logic [7:0]  bram_dout = 8'h00;
  logic        bram_en, sample_valid, active, done, fmt_err;

  logic [7:0]  mem [0:4095];
  int          vectors = 0, miscompares = 0;
  int          cyc = 0, en_count = 0, done_count = 0, done_cyc = 0, last_acc_cyc = 0, valid_cycles = 0;
  logic [11:0] last_addr = '0;
  logic [11:0] acc_q[$];

  always #5 clk = ~clk;

  wac_sample_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples), .busy_wr(busy_wr),
    .bram_dout(bram_dout), .bram_addr(bram_addr), .bram_en(bram_en),
    .sample_out(sample_out), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .active(active), .done(done), .fmt_err(fmt_err)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bram_en) bram_dout <= mem[bram_addr];
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bram_en) begin en_count++; last_addr = bram_addr; end
      if (done) begin done_count++; done_cyc = cyc; end
      if (sample_valid) valid_cycles++;
      if (sample_valid && sample_ready) begin acc_q.push_back(sample_out); last_acc_cyc = cyc; end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(input logic [11:0] n);
    start = 1'b1; n_samples = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int bound, output bit seen);
    int i = 0;
    while (done_count == d0 && i < bound) begin tick(); i++; end
    seen = (done_count != d0);
  endtask

  function automatic logic [11:0] exp5(input int k);
    return 12'((k * 37 + 11) & 32'hFFF);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; busy_wr = 1'b0; sample_ready = 1'b0; n_samples = '0;
    tick(3);
    vectors++; if ({sample_valid, active, done, bram_en, fmt_err} !== 5'b0) begin
      miscompares++; $display("FAIL reset_ctrl: got %b want 00000", {sample_valid, active, done, bram_en, fmt_err}); end
    vectors++; if (bram_addr !== 12'h000) begin
      miscompares++; $display("FAIL reset_addr: got %h want 000", bram_addr); end
    vectors++; if (sample_out !== 12'h000) begin
      miscompares++; $display("FAIL reset_sample: got %h want 000", sample_out); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    int b = acc_q.size();
    int d0 = done_count;
    bit seen;
    mem[3] = 8'h01; mem[4] = 8'h23; mem[5] = 8'h0A; mem[6] = 8'hBC;
    sample_ready = 1'b1;
    pulse_start(12'd2);
    vectors++; if (active !== 1'b1) begin
      miscompares++; $display("FAIL basic_active: got %b want 1", active); end
    tick(3);
    vectors++; if (sample_valid !== 1'b0) begin
      miscompares++; $display("FAIL basic_early_valid: got %b want 0", sample_valid); end
    tick();
    vectors++; if (sample_valid !== 1'b1 || sample_out !== 12'h123) begin
      miscompares++; $display("FAIL basic_latency: valid %b data %h want 1 123", sample_valid, sample_out); end
    wait_done(d0, 40, seen);
    vectors++; if (!seen) begin
      miscompares++; $display("FAIL basic_done: no done within 40 cycles"); end
    vectors++; if (acc_q.size() - b !== 2 || acc_q[b] !== 12'h123 || acc_q[b+1] !== 12'hABC) begin
      miscompares++; $display("FAIL basic_data: got %0d samples, first %h want 2 samples 123 ABC", acc_q.size() - b, acc_q[b]); end
    vectors++; if (done_cyc !== last_acc_cyc + 1) begin
      miscompares++; $display("FAIL basic_done_timing: done at %0d want %0d", done_cyc, last_acc_cyc + 1); end
    vectors++; if (fmt_err !== 1'b0 || active !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL basic_end: fmt_err %b active %b done %b want 0 0 0", fmt_err, active, done); end
  endtask

  task automatic test_zero();
    int en0 = en_count;
    int v0 = valid_cycles;
    int d0 = done_count;
    pulse_start(12'd0);
    vectors++; if (done !== 1'b1 || active !== 1'b0) begin
      miscompares++; $display("FAIL zero_done: done %b active %b want 1 0", done, active); end
    tick();
    vectors++; if (done !== 1'b0) begin
      miscompares++; $display("FAIL zero_pulse: done %b want 0", done); end
    tick(3);
    vectors++; if (en_count !== en0 || valid_cycles !== v0 || done_count !== d0 + 1) begin
      miscompares++; $display("FAIL zero_quiet: en %0d valid %0d dones %0d want 0 0 1",
                              en_count - en0, valid_cycles - v0, done_count - d0); end
  endtask

  task automatic test_backpressure();
    int b = acc_q.size();
    int d0 = done_count;
    bit seen;
    mem[7] = 8'h07; mem[8] = 8'h89;
    sample_ready = 1'b0;
    pulse_start(12'd3);
    tick(4);
    for (int i = 0; i < 7; i++) begin
      tick();
      vectors++; if (sample_valid !== 1'b1 || sample_out !== 12'h123 || acc_q.size() !== b) begin
        miscompares++; $display("FAIL hold_%0d: valid %b data %h accepted %0d want 1 123 0",
                                i, sample_valid, sample_out, acc_q.size() - b); end
    end
    sample_ready = 1'b1;
    wait_done(d0, 60, seen);
    vectors++; if (!seen || acc_q.size() - b !== 3) begin
      miscompares++; $display("FAIL bp_count: seen %b samples %0d want 1 3", seen, acc_q.size() - b); end
    else begin
      vectors++; if (acc_q[b] !== 12'h123 || acc_q[b+1] !== 12'hABC || acc_q[b+2] !== 12'h789) begin
        miscompares++; $display("FAIL bp_order: got %h %h %h want 123 ABC 789", acc_q[b], acc_q[b+1], acc_q[b+2]); end
    end
  endtask

  task automatic test_busy();
    int b = acc_q.size();
    int d0 = done_count;
    int en0 = en_count;
    int en1;
    int i = 0;
    bit seen;
    sample_ready = 1'b1;
    busy_wr = 1'b1;
    pulse_start(12'd2);
    vectors++; if (active !== 1'b1) begin
      miscompares++; $display("FAIL busy_start: active %b want 1", active); end
    tick(3);
    vectors++; if (en_count !== en0 || bram_en !== 1'b0) begin
      miscompares++; $display("FAIL busy_hold0: reads %0d want 0", en_count - en0); end
    busy_wr = 1'b0;
    tick();
    vectors++; if (bram_en !== 1'b1 || bram_addr !== 12'h003) begin
      miscompares++; $display("FAIL busy_resume0: en %b addr %h want 1 003", bram_en, bram_addr); end
    while (sample_valid !== 1'b1 && i < 20) begin tick(); i++; end
    busy_wr = 1'b1;
    en1 = en_count;
    tick(10);
    vectors++; if (en_count !== en1 || bram_en !== 1'b0) begin
      miscompares++; $display("FAIL busy_hold1: reads %0d want 0", en_count - en1); end
    busy_wr = 1'b0;
    tick();
    vectors++; if (bram_en !== 1'b1 || bram_addr !== 12'h005) begin
      miscompares++; $display("FAIL busy_resume1: en %b addr %h want 1 005", bram_en, bram_addr); end
    wait_done(d0, 40, seen);
    vectors++; if (!seen || acc_q.size() - b !== 2 || acc_q[b] !== 12'h123 || acc_q[b+1] !== 12'hABC) begin
      miscompares++; $display("FAIL busy_data: seen %b samples %0d want 1 2 (123 ABC)", seen, acc_q.size() - b); end
  endtask

  task automatic test_clamp();
    int b = acc_q.size();
    int d0 = done_count;
    int bad = -1;
    bit seen;
    logic [11:0] v;
    for (int k = 0; k < 2046; k++) begin
      v = exp5(k);
      mem[3 + 2*k] = {4'h0, v[11:8]};
      mem[4 + 2*k] = v[7:0];
    end
    sample_ready = 1'b1;
    pulse_start(12'hFFF);
    tick(100);
    pulse_start(12'd1);
    wait_done(d0, 11000, seen);
    vectors++; if (!seen || acc_q.size() - b !== 2046) begin
      miscompares++; $display("FAIL clamp_count: seen %b samples %0d want 1 2046", seen, acc_q.size() - b); end
    for (int k = 0; k < 2046 && k < acc_q.size() - b; k++)
      if (bad < 0 && acc_q[b+k] !== exp5(k)) bad = k;
    vectors++; if (bad >= 0) begin
      miscompares++; $display("FAIL clamp_data: index %0d got %h want %h", bad, acc_q[b+bad], exp5(bad)); end
    vectors++; if (last_addr !== 12'hFFE || bram_addr !== 12'hFFE || bram_en !== 1'b0) begin
      miscompares++; $display("FAIL clamp_addr: last %h held %h en %b want FFE FFE 0", last_addr, bram_addr, bram_en); end
    tick(3);
    vectors++; if (active !== 1'b0 || done_count !== d0 + 1 || fmt_err !== 1'b0) begin
      miscompares++; $display("FAIL clamp_end: active %b dones %0d fmt_err %b want 0 1 0", active, done_count - d0, fmt_err); end
  endtask

  task automatic test_fmt_reset();
    int b = acc_q.size();
    int d0 = done_count;
    bit seen;
    mem[3] = 8'hF1; mem[4] = 8'h23;
    sample_ready = 1'b1;
    pulse_start(12'd1);
    wait_done(d0, 30, seen);
    vectors++; if (!seen || acc_q.size() - b !== 1 || acc_q[b] !== 12'h123 || fmt_err !== 1'b1) begin
      miscompares++; $display("FAIL fmt: seen %b samples %0d fmt_err %b want 1 1 1 (data 123)", seen, acc_q.size() - b, fmt_err); end
    sample_ready = 1'b0;
    pulse_start(12'd2);
    tick(5);
    d0 = done_count;
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({sample_valid, active, done, bram_en, fmt_err} !== 5'b0 || bram_addr !== 12'h0 || sample_out !== 12'h0) begin
      miscompares++; $display("FAIL async_reset: ctrl %b addr %h data %h want 00000 000 000",
                              {sample_valid, active, done, bram_en, fmt_err}, bram_addr, sample_out); end
    tick(2);
    rst_n = 1'b1;
    tick(6);
    vectors++; if (done_count !== d0 || active !== 1'b0 || sample_valid !== 1'b0) begin
      miscompares++; $display("FAIL post_reset: dones %0d active %b valid %b want 0 0 0", done_count - d0, active, sample_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_busy();
    test_clamp();
    test_fmt_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
